// File: rtl/id_iex.sv
// ID/EX datapath pipeline register: captures decode-stage operands/indices, 1-cycle latency.
// No backpressure: loads every edge; synchronous active-low reset and clear both insert an all-zero bubble.
module id_iex #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [XLEN-1:0] rd1d,
  input  logic [XLEN-1:0] rd2d,
  input  logic [XLEN-1:0] pcd,
  input  logic [REGW-1:0] rs1d,
  input  logic [REGW-1:0] rs2d,
  input  logic [REGW-1:0] rdd,
  input  logic [XLEN-1:0] immextd,
  input  logic [XLEN-1:0] pcplus4d,
  output logic [XLEN-1:0] rd1e,
  output logic [XLEN-1:0] rd2e,
  output logic [XLEN-1:0] pce,
  output logic [REGW-1:0] rs1e,
  output logic [REGW-1:0] rs2e,
  output logic [REGW-1:0] rde,
  output logic [XLEN-1:0] immexte,
  output logic [XLEN-1:0] pcplus4e
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pcplus4;
  } fields_t;

  fields_t d_fields;
  fields_t e_fields;

  assign d_fields = '{
    rd1:     rd1d,
    rd2:     rd2d,
    pc:      pcd,
    rs1:     rs1d,
    rs2:     rs2d,
    rd:      rdd,
    imm:     immextd,
    pcplus4: pcplus4d
  };

  // A bubble has rd = x0, so it can never produce an architectural write.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      e_fields <= '0;
    end else begin
      e_fields <= d_fields;
    end
  end

  assign rd1e     = e_fields.rd1;
  assign rd2e     = e_fields.rd2;
  assign pce      = e_fields.pc;
  assign rs1e     = e_fields.rs1;
  assign rs2e     = e_fields.rs2;
  assign rde      = e_fields.rd;
  assign immexte  = e_fields.imm;
  assign pcplus4e = e_fields.pcplus4;

endmodule

// File: tb/tb_id_iex.sv
// Directed self-checking bench for the ID/EX datapath register.
module tb_id_iex;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [31:0] rd1d, rd2d, pcd, immextd, pcplus4d;
  logic [4:0]  rs1d, rs2d, rdd;
  logic [31:0] rd1e, rd2e, pce, immexte, pcplus4e;
  logic [4:0]  rs1e, rs2e, rde;

  int errors = 0;
  int checks = 0;

  logic [174:0] obs;
  logic [174:0] load_vec;
  assign obs = {rd1e, rd2e, pce, rs1e, rs2e, rde, immexte, pcplus4e};

  id_iex #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .rd1d(rd1d), .rd2d(rd2d), .pcd(pcd), .rs1d(rs1d), .rs2d(rs2d), .rdd(rdd),
    .immextd(immextd), .pcplus4d(pcplus4d),
    .rd1e(rd1e), .rd2e(rd2e), .pce(pce), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
    .immexte(immexte), .pcplus4e(pcplus4e)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load_vector();
    rd1d = 32'hA0000001; rd2d = 32'hA0000002; pcd = 32'h00400000;
    rs1d = 5'd5; rs2d = 5'd6; rdd = 5'd7;
    immextd = 32'hDEADBEEF; pcplus4d = 32'h00400004;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd1d = $urandom; rd2d = $urandom; pcd = $urandom; immextd = $urandom;
      pcplus4d = $urandom; rs1d = 5'($urandom); rs2d = 5'($urandom); rdd = 5'($urandom | 1);
      tick();
      checks++;
      if (obs !== 175'd0) begin
        errors++;
        $display("FAIL reset_edge%0d got=%h exp=0", i, obs);
      end
    end
  endtask

  task automatic test_load();
    reset = 1'b1; clear = 1'b0;
    drive_load_vector();
    tick();
    checks++;
    if (obs !== load_vec) begin
      errors++;
      $display("FAIL normal_load got=%h exp=%h", obs, load_vec);
    end
    checks++;
    if (rde !== 5'd7 || rs1e !== 5'd5 || pce !== 32'h00400000) begin
      errors++;
      $display("FAIL load_fields rs1e=%0d rde=%0d pce=%h exp 5/7/00400000", rs1e, rde, pce);
    end
  endtask

  task automatic test_flush();
    clear = 1'b1;
    tick();
    checks++;
    if (obs !== 175'd0) begin
      errors++;
      $display("FAIL flush got=%h exp=0", obs);
    end
    clear = 1'b0;
    tick();
    checks++;
    if (obs !== load_vec) begin
      errors++;
      $display("FAIL flush_reload got=%h exp=%h", obs, load_vec);
    end
    // Two-cycle clear holds the bubble for both edges.
    clear = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 175'd0) begin
      errors++;
      $display("FAIL flush_two_cycles got=%h exp=0", obs);
    end
    clear = 1'b0;
    tick();
    checks++;
    if (obs !== load_vec) begin
      errors++;
      $display("FAIL flush_two_reload got=%h exp=%h", obs, load_vec);
    end
  endtask

  task automatic test_reset_mid();
    rd1d = 32'h12345678;
    reset = 1'b0;
    #2;
    checks++;
    if (obs !== load_vec) begin
      errors++;
      $display("FAIL reset_between_edges got=%h exp=%h", obs, load_vec);
    end
    tick();
    checks++;
    if (obs !== 175'd0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=0", obs);
    end
    checks++;
    if (rd1e === 32'h12345678) begin
      errors++;
      $display("FAIL reset_mid_rd1e got=%h exp=00000000", rd1e);
    end
    reset = 1'b1;
    drive_load_vector();
  endtask

  task automatic test_reset_clear();
    tick();
    reset = 1'b0; clear = 1'b1;
    tick();
    checks++;
    if (obs !== 175'd0) begin
      errors++;
      $display("FAIL reset_and_clear got=%h exp=0", obs);
    end
    reset = 1'b1; clear = 1'b0;
    tick();
    checks++;
    if (obs !== load_vec) begin
      errors++;
      $display("FAIL reset_clear_release got=%h exp=%h", obs, load_vec);
    end
  endtask

  task automatic test_back_to_back();
    logic [174:0] exp_vec;
    reset = 1'b1; clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd1d = 32'h1000_0000 + i; rd2d = 32'h2000_0000 + (i << 4);
      pcd = 32'(i * 4); pcplus4d = 32'(i * 4 + 4);
      rs1d = 5'(i + 1); rs2d = 5'(i + 9); rdd = 5'(31 - i);
      immextd = 32'hFFFF_FF00 | 32'(i);
      exp_vec = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i << 4), 32'(i * 4),
                 5'(i + 1), 5'(i + 9), 5'(31 - i), 32'hFFFF_FF00 | 32'(i), 32'(i * 4 + 4)};
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL stream_%0d got=%h exp=%h", i, obs, exp_vec);
      end
    end
  endtask

  initial begin
    load_vec = {32'hA0000001, 32'hA0000002, 32'h00400000, 5'd5, 5'd6, 5'd7,
                32'hDEADBEEF, 32'h00400004};
    test_reset();
    test_load();
    test_flush();
    test_reset_mid();
    test_reset_clear();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_iex.md
# id_iex

Decode-to-execute (ID/EX) pipeline register for the pipelined RISC-V core. On each rising clock edge it captures the decode-stage datapath values and presents them to the execute stage one cycle later. It has a synchronous reset and a synchronous flush (`clear`), which inserts a bubble on branch/jump redirect or load-use hazard. It holds datapath fields only; control signals are carried by a separate register.

## Interface

Parameters:
- `XLEN`, default 32: datapath width (register data, PC, immediate).
- `REGW`, default 5: register-index width.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `clear`, input, 1: synchronous flush, active-high.
- `rd1d`, input, XLEN: register-file read port 1 data (decode).
- `rd2d`, input, XLEN: register-file read port 2 data (decode).
- `pcd`, input, XLEN: PC of the decode-stage instruction.
- `rs1d`, input, REGW: source register 1 index.
- `rs2d`, input, REGW: source register 2 index.
- `rdd`, input, REGW: destination register index.
- `immextd`, input, XLEN: sign-extended immediate.
- `pcplus4d`, input, XLEN: PC+4 of the decode instruction.
- `rd1e`, `rd2e`, `pce`, `immexte`, `pcplus4e`, output, XLEN: registered copies of the matching `*d` inputs.
- `rs1e`, `rs2e`, `rde`, output, REGW: registered copies of `rs1d`, `rs2d`, `rdd`.

## Operation

- Every output is driven directly by a flip-flop. There is no combinational path from input to output.
- Update priority on each rising edge of `clk`:
  1. `reset == 0`: all outputs become 0.
  2. Otherwise, if `clear == 1`: all outputs become 0 (bubble; `rde = 0` targets x0, so no architectural write).
  3. Otherwise: each `*e` output takes the value of its `*d` input.
- There is no enable or stall input. The register loads on every cycle that is not reset or cleared.
- Values are copied bit-exact, with no arithmetic and no width conversion.

## Timing

- Latency is 1 cycle: an input value sampled at edge N is visible on the outputs right after edge N and holds until edge N+1.
- Reset value: every output is 0. The outputs are undefined only before the first edge with `reset == 0`. Reset is never asynchronous, so asserting `reset` between edges leaves the outputs unchanged until the next rising edge.
- Reset asserted in mid-stream discards the in-flight instruction at the next edge.
- `clear` and `reset` asserted together give all zeros (reset wins; the result is identical).
- `clear` lasts exactly as many cycles as it is held high. On the first edge after `clear` deasserts, normal loading resumes with the current inputs.
- Input changes between edges have no effect; only the values present at the rising edge matter.

## Test plan

- Reset: hold `reset = 0` for 2 edges with random inputs -> every output reads 0.
- Normal load: `reset = 1`, `clear = 0`, drive `rd1d = A0000001`, `rd2d = A0000002`, `pcd = 00400000`, `rs1d = 5`, `rs2d = 6`, `rdd = 7`, `immextd = DEADBEEF`, `pcplus4d = 00400004`, then one edge -> each output equals its input value.
- Flush: after the load, set `clear = 1` for one edge -> all outputs are 0. Drop `clear`, apply one more edge -> outputs reload from the held inputs.
- Reset mid-operation: outputs loaded, change `rd1d` to 12345678, drive `reset = 0` before the next edge -> after that edge all outputs are 0, and `rd1e` is never 12345678.
- Simultaneous reset and clear: `reset = 0` and `clear = 1` on the same edge -> all outputs 0. Release both -> the next edge loads the inputs.
- Back-to-back streaming: change inputs every cycle for 8 cycles (for example, `pcd` = 0, 4, 8, ...) -> outputs at edge N+1 match the inputs applied at edge N, with no skips or duplicates.
